// File: rtl/vm_order_front_pkg.sv
// ---------------------------------------------------------------------------
// vm_pkg
// Shared definitions for the vending-machine order front end:
//   - coin selector encodings and their values, plus a decode function
//   - PID_IDLE, the product code driven to the core between orders
//   - error codes reported on errCode
//   - FSM state encoding (2 bits)
// ---------------------------------------------------------------------------
package vm_pkg;

   typedef enum logic [1:0] {
      COIN_1  = 2'b00,
      COIN_5  = 2'b01,
      COIN_10 = 2'b10,
      COIN_20 = 2'b11
   } coin_t;

   localparam logic [5:0] VAL_COIN_1  = 6'd1;
   localparam logic [5:0] VAL_COIN_5  = 6'd5;
   localparam logic [5:0] VAL_COIN_10 = 6'd10;
   localparam logic [5:0] VAL_COIN_20 = 6'd20;

   // Product code that makes the core flag only invalidProduct and never vend.
   localparam logic [2:0] PID_IDLE = 3'b111;

   localparam logic [2:0] ERR_INVALID_PRODUCT = 3'd1;
   localparam logic [2:0] ERR_UNAVAILABLE     = 3'd2;
   localparam logic [2:0] ERR_INSUFFICIENT    = 3'd3;
   localparam logic [2:0] ERR_NOT_EXACT       = 3'd4;
   localparam logic [2:0] ERR_SUGAR           = 3'd5;
   localparam logic [2:0] ERR_UNKNOWN         = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_COLLECT = 2'b01,
      ST_ISSUE   = 2'b10,
      ST_RESULT  = 2'b11
   } state_t;

   // Translates the 2-bit coin selector into its credit value.
   function automatic logic [5:0] coinValue(input logic [1:0] sel);
      logic [5:0] val;
      case (coin_t'(sel))
         COIN_1:  val = VAL_COIN_1;
         COIN_5:  val = VAL_COIN_5;
         COIN_10: val = VAL_COIN_10;
         COIN_20: val = VAL_COIN_20;
         default: val = VAL_COIN_1;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/vm_order_front_if.sv
// ---------------------------------------------------------------------------
// vm_order_front_if
// Bus between the order front end and the two-machine vending core.
//   money/vm/productID/sugar          : transaction, front -> core
//   moneyLeft and the six status flags : registered result, core -> front
// Modports: master = front end side, slave = core side.
// ---------------------------------------------------------------------------
interface vm_order_front_if;

   logic [5:0] money;
   logic       vm;
   logic [2:0] productID;
   logic       sugar;

   logic [5:0] moneyLeft;
   logic       productReady;
   logic       productUnavailable;
   logic       insufficientFund;
   logic       notExactFund;
   logic       invalidProduct;
   logic       sugarUnsuitable;

   modport master (
      output money, vm, productID, sugar,
      input  moneyLeft, productReady, productUnavailable, insufficientFund,
             notExactFund, invalidProduct, sugarUnsuitable
   );

   modport slave (
      input  money, vm, productID, sugar,
      output moneyLeft, productReady, productUnavailable, insufficientFund,
             notExactFund, invalidProduct, sugarUnsuitable
   );

endinterface

// File: rtl/vm_order_front.sv
// ---------------------------------------------------------------------------
// vm_order_front
// Customer-facing front end for the vending core. Collects coins into a
// credit register, latches one selection, issues one transaction to the core
// and reports the core's result to the panel.
// Ports:
//   CLK, RST            : clock (rising edge), asynchronous active-high reset
//   coinValid, coinSel  : coin strobe and coin type
//   selValid, selVm, selProductID, selSugar : product selection request
//   cancel              : refund request
//   core                : bus to the vending core (master side)
//   credit, busy        : current credit, order in flight
//   coinReject, dispensed, changeValid, errValid : one-cycle pulses
//   changeAmount, errCode : qualified by changeValid / errValid
// ---------------------------------------------------------------------------
module vm_order_front
   import vm_pkg::*;
#(
   parameter int CREDIT_MAX = 63
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   coinValid,
   input  logic [1:0]             coinSel,
   input  logic                   selValid,
   input  logic                   selVm,
   input  logic [2:0]             selProductID,
   input  logic                   selSugar,
   input  logic                   cancel,
   vm_order_front_if.master       core,
   output logic [5:0]             credit,
   output logic                   busy,
   output logic                   coinReject,
   output logic                   dispensed,
   output logic                   changeValid,
   output logic [5:0]             changeAmount,
   output logic [2:0]             errCode,
   output logic                   errValid
);

   state_t     state;
   logic       latVm;
   logic [2:0] latPid;
   logic       latSugar;
   logic       orderOnBus;

   logic [6:0] coinSum;
   logic       coinFits;
   logic       inFront;
   logic       doCancel;
   logic       doSelect;
   logic       doCoin;
   logic       sampleResult;
   logic [2:0] errSel;

   // Decision logic shared by the state and output registers. The coin sum
   // is kept 7 bits wide so a 6-bit wrap cannot sneak past the limit check.
   // orderOnBus marks the RESULT cycle in which the core is still sampling
   // our transaction; its answer is only readable one cycle later.
   always_comb begin
      coinSum      = {1'b0, credit} + {1'b0, coinValue(coinSel)};
      coinFits     = (coinSum <= 7'(CREDIT_MAX));
      inFront      = (state == ST_IDLE) || (state == ST_COLLECT);
      doCancel     = inFront && cancel && (credit != 6'd0);
      doSelect     = inFront && !doCancel && selValid;
      doCoin       = inFront && !doCancel && !doSelect && coinValid && coinFits;
      sampleResult = (state == ST_RESULT) && !orderOnBus;
      if (core.invalidProduct)
         errSel = ERR_INVALID_PRODUCT;
      else if (core.productUnavailable)
         errSel = ERR_UNAVAILABLE;
      else if (core.insufficientFund)
         errSel = ERR_INSUFFICIENT;
      else if (core.notExactFund)
         errSel = ERR_NOT_EXACT;
      else if (core.sugarUnsuitable)
         errSel = ERR_SUGAR;
      else
         errSel = ERR_UNKNOWN;
   end

   // State, credit and latched selection. A failed order returns whatever
   // the core says is left, so the customer can retry or cancel.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= ST_IDLE;
         credit     <= 6'd0;
         latVm      <= 1'b0;
         latPid     <= PID_IDLE;
         latSugar   <= 1'b0;
         orderOnBus <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_COLLECT: begin
               if (doCancel) begin
                  credit <= 6'd0;
                  state  <= ST_IDLE;
               end else if (doSelect) begin
                  latVm    <= selVm;
                  latPid   <= selProductID;
                  latSugar <= selSugar & selVm;
                  state    <= ST_ISSUE;
               end else if (doCoin) begin
                  credit <= coinSum[5:0];
                  state  <= ST_COLLECT;
               end
            end
            ST_ISSUE: begin
               orderOnBus <= 1'b1;
               state      <= ST_RESULT;
            end
            ST_RESULT: begin
               if (orderOnBus) begin
                  orderOnBus <= 1'b0;
               end else if (core.productReady) begin
                  credit <= 6'd0;
                  state  <= ST_IDLE;
               end else begin
                  credit <= core.moneyLeft;
                  state  <= (core.moneyLeft != 6'd0) ? ST_COLLECT : ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Registered panel and core outputs. Pulses default low every cycle;
   // changeAmount and errCode hold their last value between pulses. The core
   // sees the order only for the cycle after ISSUE and the harmless idle
   // transaction at all other times.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         busy           <= 1'b0;
         coinReject     <= 1'b0;
         dispensed      <= 1'b0;
         changeValid    <= 1'b0;
         changeAmount   <= 6'd0;
         errValid       <= 1'b0;
         errCode        <= 3'd0;
         core.money     <= 6'd0;
         core.vm        <= 1'b0;
         core.productID <= PID_IDLE;
         core.sugar     <= 1'b0;
      end else begin
         busy        <= (state == ST_ISSUE) || ((state == ST_RESULT) && orderOnBus);
         coinReject  <= coinValid && !doCoin;
         dispensed   <= sampleResult && core.productReady;
         errValid    <= sampleResult && !core.productReady;
         changeValid <= doCancel ||
                        (sampleResult && core.productReady && (core.moneyLeft != 6'd0));
         if (doCancel)
            changeAmount <= credit;
         else if (sampleResult && core.productReady && (core.moneyLeft != 6'd0))
            changeAmount <= core.moneyLeft;
         if (sampleResult && !core.productReady)
            errCode <= errSel;
         if (state == ST_ISSUE) begin
            core.money     <= credit;
            core.vm        <= latVm;
            core.productID <= latPid;
            core.sugar     <= latSugar;
         end else begin
            core.money     <= 6'd0;
            core.vm        <= 1'b0;
            core.productID <= PID_IDLE;
            core.sugar     <= 1'b0;
         end
      end
   end

endmodule
